// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle HI/LO multiply/divide unit (mult, div, madd/msub when MULT_DIV_MADD_EN is defined)
`timescale 1ns/1ps
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_BUSY = 1'b1;
    // counter holds remaining edges minus one; commit happens when it reads zero
    localparam logic [3:0] LAT_MUL = 4'd4;
    localparam logic [3:0] LAT_DIV = 4'd9;

    logic        state;
    logic [3:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;

    logic        op_legal;
    logic        accept;
    logic        is_div;
    logic        is_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] result;

`ifdef MULT_DIV_MADD_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = ~op[2];
`endif

    assign busy      = (state == ST_BUSY);
    assign accept    = (state == ST_IDLE) && start && op_legal;
    assign is_div    = (op_q[2:1] == 2'b01);
    assign is_signed = ~op_q[0];

    // sign/zero extension to 64 bits lets one truncated multiplier serve both signednesses
    assign mul_a   = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign mul_b   = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = mul_a * mul_b;

    // signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000 rem 0
    assign a_neg   = is_signed & a_q[31];
    assign b_neg   = is_signed & b_q[31];
    assign a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    assign div_den = (b_q == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / div_den;
    assign r_mag   = a_mag % div_den;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    // hi/lo cannot change while busy, so they still hold the start-edge accumulator here
    always_comb begin
        result = product;
        if (is_div) begin
            result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quot};
        end
`ifdef MULT_DIV_MADD_EN
        if (op_q[2]) begin
            result = op_q[1] ? ({hi, lo} - product) : ({hi, lo} + product);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 3'd0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op;
                cnt   <= (op[2:1] == 2'b01) ? LAT_DIV : LAT_MUL;
                state <= ST_BUSY;
            end else if (!start) begin
                if (wr_hi) hi <= wdata;
                if (wr_lo) lo <= wdata;
            end
        end else begin
            if (cnt == 4'd0) begin
                {hi, lo} <= result;
                state    <= ST_IDLE;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit (honours MULT_DIV_MADD_EN)
`timescale 1ns/1ps
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_hl = 64'd0;
    bit          expect_abort = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit op_ok(input logic [2:0] o);
`ifdef MULT_DIV_MADD_EN
        return 1'b1;
`else
        return !o[2];
`endif
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] acc);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     prod;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o[0]) prod = ux * uy;
        else      prod = sx * sy;
        case (o)
            3'd2, 3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            3'd4, 3'd5: return acc + prod;
            3'd6, 3'd7: return acc - prod;
            default:    return prod;
        endcase
    endfunction

    task automatic wait_idle(input string name);
        int g = 0;
        while (busy !== 1'b0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check({name, "_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic whi, input logic wlo,
                         input logic [31:0] wd);
        exp_t e;
        wait_idle({name, "_wait"});
        start = 1'b1; op = o; a = x; b = y;
        wr_hi = whi; wr_lo = wlo; wdata = wd;
        if (op_ok(o)) begin
            e.res  = ref_result(o, x, y, m_hl);
            e.lat  = (o == 3'd2 || o == 3'd3) ? 10 : 5;
            e.name = name;
            sb_q.push_back(e);
            m_hl = e.res;
        end
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        if (!op_ok(o)) begin
            check({name, "_ignored_busy"}, 64'(busy), 64'd0);
            check({name, "_ignored_hilo"}, {hi, lo}, m_hl);
        end
    endtask

    task automatic mtw(input string name, input logic whi, input logic wlo, input logic [31:0] d);
        wait_idle({name, "_wait"});
        wr_hi = whi; wr_lo = wlo; wdata = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (whi) m_hl[63:32] = d;
        if (wlo) m_hl[31:0]  = d;
        check(name, {hi, lo}, m_hl);
    endtask

    // monitor: every falling edge of busy is a commit that must match the oldest expectation
    initial begin
        bit          pb;
        bit          bz;
        bit          held;
        int          cyc;
        logic [63:0] snap;
        exp_t        e;
        pb = 1'b0; held = 1'b1; cyc = 0; snap = 64'd0;
        forever begin
            @(negedge clk);
            bz = (busy === 1'b1);
            if (bz && !pb) begin
                snap = {hi, lo};
                held = 1'b1;
                cyc  = 0;
            end
            if (bz) begin
                cyc++;
                if ({hi, lo} !== snap) held = 1'b0;
            end
            if (!bz && pb) begin
                if (sb_q.size() == 0) begin
                    if (!expect_abort) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_commit: got hi=%h lo=%h expected no commit", hi, lo);
                    end
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_hilo"}, {hi, lo}, e.res);
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.lat));
                    check({e.name, "_hold"}, 64'(held), 64'd1);
                end
            end
            pb = bz;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit          clean;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          sel;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        issue("multu_ff_x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_idle("multu_done");
        check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        issue("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_idle("div_done");
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue("divu_by0", 3'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0);
        wait_idle("divu0_done");
        check("divu0_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

        issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        wait_idle("ovf_done");
        check("ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // start and mthi pulsed while busy must both be dropped
        issue("multu_busy_writes", 3'd1, 32'h10, 32'h20, 1'b0, 1'b0, 32'd0);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; wr_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        wait_idle("busy_writes_done");
        check("busy_writes_const", {hi, lo}, 64'h0000_0000_0000_0200);

        // reset in the third busy cycle aborts without commit
        issue("mult_abort", 3'd0, 32'd7, 32'd9, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        expect_abort = 1'b1;
        sb_q.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hl = 64'd0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        clean = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || {hi, lo} !== 64'd0) clean = 1'b0;
        end
        check("abort_no_late_commit", 64'(clean), 64'd1);
        expect_abort = 1'b0;

        mtw("mt_both_zero", 1'b1, 1'b1, 32'd0);
        mtw("mtlo_10", 1'b0, 1'b1, 32'd10);
        issue("madd_3x4", 3'd4, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
        wait_idle("madd_done");
`ifdef MULT_DIV_MADD_EN
        check("madd_const", {hi, lo}, 64'd22);
`else
        check("madd_const", {hi, lo}, 64'd10);
`endif

        issue("prio_mult_2x2", 3'd0, 32'd2, 32'd2, 1'b0, 1'b1, 32'd9);
        wait_idle("prio_done");
        check("prio_const", {hi, lo}, 64'd4);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                mtw("rand_mt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                ro = 3'($urandom_range(0, 7));
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 7))
                    0: rb = 32'd0;
                    1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                    2: begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(1, 5)); end
                    3: rb = 32'hFFFF_FFFF;
                    default: ;
                endcase
                issue("rand_op", ro, ra, rb, 1'b0, 1'b0, 32'd0);
            end
        end

        wait_idle("final");
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin the operation selected by op, sampled at a rising edge.
REQ-004 SHALL have port op, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
REQ-005 SHALL have ports a and b, input, 32 bits each: operands (rs, rt).
REQ-006 SHALL have ports wr_hi and wr_lo, input, 1 bit each: mthi and mtlo strobes.
REQ-007 SHALL have port wdata, input, 32 bits: data for mthi/mtlo.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO, fed to the E-stage hie/loe path.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and BUSY, with a latency counter (4 bits minimum).
REQ-011 SHALL, in IDLE with start=1 and a legal op at edge T, latch a, b and op, load the counter, and enter BUSY.
  - busy SHALL be 1 from after T through the edge ending the latency.
REQ-012 SHALL use a latency of 5 cycles for mult, multu, madd, maddu, msub and msubu, and 10 cycles for div and divu.
REQ-013 SHALL update hi/lo only on the edge where the counter expires; at that same edge busy SHALL drop and the FSM SHALL return to IDLE.
  - hi/lo SHALL hold their old values during BUSY.
REQ-014 SHALL compute mult/multu as the 64-bit signed/unsigned product, with {hi,lo} = product.
REQ-015 SHALL compute madd(u) as {hi,lo} += product and msub(u) as {hi,lo} -= product.
  - Uses {hi,lo} as of the start edge; modulo 2^64; no overflow flag.
REQ-016 SHALL compute div (signed) as lo = quotient truncated toward zero and hi = remainder with the sign of the dividend; divu SHALL be unsigned.
REQ-017 SHALL, for divide by zero (b=0, div or divu), produce lo=0xFFFFFFFF and hi=a after the full 10 cycles.
REQ-018 SHALL, for signed overflow (a=0x80000000, b=0xFFFFFFFF, div), produce lo=0x80000000 and hi=0.
REQ-019 SHALL ignore start while busy=1; the in-flight operation is unaffected.
REQ-020 SHALL, when wr_hi/wr_lo=1 in IDLE with start=0, load hi/lo from wdata at that edge.
  - wr_hi and wr_lo together SHALL load both registers.
REQ-021 SHALL ignore wr_hi/wr_lo while busy=1; the pipeline stalls mthi/mtlo.
REQ-022 SHALL give start priority over wr_hi/wr_lo when both are 1 in IDLE, dropping the write.
REQ-023 SHALL accept a back-to-back start in the cycle after busy falls; that operation uses the just-committed hi/lo for madd/msub.

Reset
REQ-024 SHALL, on reset=1 at an edge, set hi=0, lo=0 and busy=0, enter IDLE, and clear the counter.
REQ-025 SHALL, on reset during BUSY, abort the operation with no commit; reset SHALL override start and wr_hi/wr_lo.

Configuration
REQ-026 SHALL support the macro MULT_DIV_MADD_EN.
  - When defined: ops 100-111 operate per REQ-015.
  - When undefined: start with op[2]=1 SHALL be ignored (FSM stays IDLE, busy stays 0, hi/lo unchanged), and the accumulate adder SHALL be absent.

Verification
REQ-027 SHALL cover multu: after reset, start with a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-028 SHALL cover div: start with a=-7, b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); also a=5, b=0, divu -> lo=0xFFFFFFFF, hi=5.
REQ-029 SHALL cover busy-time writes: during BUSY pulse start (mult 3x3) and wr_hi with wdata=0x1234 -> both ignored; the original result commits.
REQ-030 SHALL cover reset mid-op: reset asserted in the 3rd busy cycle -> next cycle busy=0, hi=lo=0, and no later commit.
REQ-031 SHALL cover madd: mtlo 10, then madd a=3, b=4 with MULT_DIV_MADD_EN -> hi=0, lo=22; without the macro -> busy stays 0, lo=10.
REQ-032 SHALL cover priority: start (mult 2x2) and wr_lo (wdata=9) in the same IDLE cycle -> lo=4 after 5 cycles; 9 is never visible.
